// File: rtl/gated_mac_seq.sv
// Time-multiplexed gated multiply-accumulate: result = offset + sum(a*b*(1-gate))
// over N_TERMS handshaked terms, wrapping modulo 2^ACC_W.
module gated_mac_seq #(
  parameter int unsigned A_W     = 9,
  parameter int unsigned B_W     = 8,
  parameter int unsigned OFF_W   = 7,
  parameter int unsigned ACC_W   = 17,
  parameter int unsigned N_TERMS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OFF_W-1:0] offset,
  output logic             busy,
  input  logic             term_valid,
  output logic             term_ready,
  input  logic [A_W-1:0]   term_a,
  input  logic [B_W-1:0]   term_b,
  input  logic             term_gate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);

  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [P_W-1:0]   w_prod;
  logic [P_W-1:0]   r_prod;
  logic             r_gate;
  logic             r_pvalid;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] r_res;
  logic             w_start_hs;
  logic             w_term_hs;
  logic             w_last_term;
  logic             w_res_hs;

  assign w_prod = {{B_W{1'b0}}, term_a} * {{A_W{1'b0}}, term_b};

  always_comb begin
    w_start_hs  = (r_state == S_IDLE) && start;
    w_term_hs   = (r_state == S_RUN) && term_valid;
    w_last_term = w_term_hs && (r_cnt == LAST_CNT);
    w_res_hs    = (r_state == S_DONE) && res_ready;
    w_acc_nxt   = r_acc;
    if (r_pvalid && !r_gate) begin
      w_acc_nxt = r_acc + ACC_W'(r_prod);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_hs)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last_term) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  if (w_res_hs)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stage 1 registers the product of the accepted term; stage 2 folds it into
  // the accumulator one cycle later, which is why DRAIN exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod   <= '0;
      r_gate   <= 1'b0;
      r_pvalid <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_res    <= '0;
    end else begin
      if (w_start_hs) begin
        r_acc <= ACC_W'(offset);
        r_cnt <= '0;
      end else begin
        r_acc <= w_acc_nxt;
        if (w_term_hs) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_term_hs) begin
        r_prod   <= w_prod;
        r_gate   <= term_gate;
        r_pvalid <= 1'b1;
      end else begin
        r_pvalid <= 1'b0;
      end
      if (r_state == S_DRAIN) begin
        r_res <= w_acc_nxt;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign term_ready = (r_state == S_RUN);
  assign res_valid  = (r_state == S_DONE);
  assign res_data   = r_res;

endmodule

// File: tb/tb_gated_mac_seq.sv
// Self-checking bench for gated_mac_seq: directed scenarios plus a randomized
// sweep checked against an arithmetic reference of offset + sum(a*b*(1-g)).
module tb_gated_mac_seq;
  localparam int unsigned A_W = 9, B_W = 8, OFF_W = 7, ACC_W = 17, NT = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [OFF_W-1:0] offset = '0;
  logic             busy;
  logic             term_valid = 1'b0;
  logic             term_ready;
  logic [A_W-1:0]   term_a = '0;
  logic [B_W-1:0]   term_b = '0;
  logic             term_gate = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [ACC_W-1:0] res_data;

  int total = 0;
  int bad = 0;

  logic [A_W-1:0] qa[NT];
  logic [B_W-1:0] qb[NT];
  logic           qg[NT];

  gated_mac_seq #(.A_W(A_W), .B_W(B_W), .OFF_W(OFF_W), .ACC_W(ACC_W), .N_TERMS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .offset(offset), .busy(busy),
    .term_valid(term_valid), .term_ready(term_ready), .term_a(term_a),
    .term_b(term_b), .term_gate(term_gate), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ACC_W-1:0] model(input logic [OFF_W-1:0] off);
    longint s;
    s = longint'(off);
    for (int i = 0; i < NT; i++) begin
      if (!qg[i]) s += longint'(qa[i]) * longint'(qb[i]);
    end
    return s[ACC_W-1:0];
  endfunction

  function automatic void fill_random(input int gate_pct);
    for (int i = 0; i < NT; i++) begin
      qa[i] = A_W'($urandom);
      qb[i] = B_W'($urandom);
      qg[i] = ($urandom_range(99) < gate_pct);
    end
  endfunction

  // Starts a job, feeds qa/qb/qg with random idle gaps, and returns once
  // res_valid is seen. lat counts cycles from the last-term cycle to res_valid.
  task automatic run_job(input logic [OFF_W-1:0] off, input int gap_pct,
                         output logic [ACC_W-1:0] res, output int lat, output logic to);
    start  = 1'b1;
    offset = off;
    step();
    start  = 1'b0;
    offset = OFF_W'($urandom);
    for (int i = 0; i < NT; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        term_valid = 1'b0;
        term_a = A_W'($urandom); term_b = B_W'($urandom); term_gate = 1'($urandom);
        step();
      end
      term_valid = 1'b1;
      term_a = qa[i]; term_b = qb[i]; term_gate = qg[i];
      step();
    end
    term_valid = 1'b0;
    term_a = A_W'($urandom); term_b = B_W'($urandom); term_gate = 1'($urandom);
    lat = 1;
    while (!res_valid && lat < 20) begin
      step();
      lat++;
    end
    to  = !res_valid;
    res = res_data;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (term_ready !== 1'b0) begin bad++; $display("FAIL reset_term_ready got=%b exp=0", term_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    total++; if (res_data !== '0) begin bad++; $display("FAIL reset_res_data got=%0d exp=0", res_data); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic;
    logic [ACC_W-1:0] r; int lat; logic to;
    qa = '{3, 10, 1, 1, 1, 1};
    qb = '{4, 10, 1, 1, 1, 1};
    qg = '{0, 1, 0, 0, 0, 0};
    res_ready = 1'b1;
    run_job(7'd5, 0, r, lat, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b exp=0", to); end
    total++; if (r !== 17'd21) begin bad++; $display("FAIL basic_res got=%0d exp=21", r); end
    total++; if (lat != 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    step();
    total++; if (res_data !== 17'd21) begin bad++; $display("FAIL basic_hold got=%0d exp=21", res_data); end
  endtask

  task automatic test_wrap;
    logic [ACC_W-1:0] r; int lat; logic to;
    for (int i = 0; i < NT; i++) begin qa[i] = 9'd511; qb[i] = 8'd255; qg[i] = 1'b0; end
    run_job(7'd127, 0, r, lat, to);
    total++; if (r !== 17'd126597) begin bad++; $display("FAIL wrap_res got=%0d exp=126597", r); end
    step();
  endtask

  task automatic test_all_gated;
    logic [ACC_W-1:0] r; int lat; logic to;
    for (int i = 0; i < NT; i++) begin qa[i] = 9'd511; qb[i] = 8'd255; qg[i] = 1'b1; end
    for (int k = 0; k < 3; k++) begin
      run_job(7'd100, 40, r, lat, to);
      total++; if (r !== 17'd100) begin bad++; $display("FAIL gated_res[%0d] got=%0d exp=100", k, r); end
      step();
    end
  endtask

  task automatic test_backpressure;
    logic [ACC_W-1:0] r, exp_r; int lat; logic to;
    fill_random(30);
    exp_r = model(7'd42);
    res_ready = 1'b0;
    run_job(7'd42, 10, r, lat, to);
    total++; if (r !== exp_r) begin bad++; $display("FAIL bp_res got=%0d exp=%0d", r, exp_r); end
    for (int c = 0; c < 10; c++) begin
      start = 1'($urandom);
      step();
      if (res_valid !== 1'b1 || res_data !== exp_r || busy !== 1'b1 || term_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%0d busy=%b tready=%b exp 1/%0d/1/0",
                 c, res_valid, res_data, busy, term_ready, exp_r);
      end
      total++;
    end
    start = 1'b0;
    res_ready = 1'b1;
    step();
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++;
      $display("FAIL bp_release got busy=%b valid=%b exp 0/0", busy, res_valid); end
    total++; if (res_data !== exp_r) begin bad++; $display("FAIL bp_after got=%0d exp=%0d", res_data, exp_r); end
  endtask

  task automatic test_reset_mid;
    logic [ACC_W-1:0] r; int lat; logic to;
    start = 1'b1; offset = 7'd77;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      term_valid = 1'b1; term_a = 9'd300; term_b = 8'd200; term_gate = 1'b0;
      step();
    end
    term_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || term_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got busy=%b tready=%b valid=%b data=%0d exp 0/0/0/0",
               busy, term_ready, res_valid, res_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL midreset_no_result got valid=%b busy=%b exp 0/0", res_valid, busy); end
    for (int i = 0; i < NT; i++) begin qa[i] = 9'd2; qb[i] = 8'd3; qg[i] = 1'b0; end
    run_job(7'd0, 0, r, lat, to);
    total++; if (r !== 17'd36) begin bad++; $display("FAIL midreset_rerun got=%0d exp=36", r); end
    step();
  endtask

  task automatic test_sweep;
    logic [ACC_W-1:0] r, exp_r; int lat; logic to; logic [OFF_W-1:0] off;
    for (int n = 0; n < 1000; n++) begin
      fill_random(int'($urandom_range(60)));
      off = OFF_W'($urandom);
      exp_r = model(off);
      res_ready = 1'b0;
      run_job(off, 20, r, lat, to);
      total++; if (to !== 1'b0 || r !== exp_r) begin bad++;
        $display("FAIL sweep[%0d] got=%0d timeout=%b exp=%0d", n, r, to, exp_r); end
      for (int w = int'($urandom_range(2)); w > 0; w--) step();
      res_ready = 1'b1;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_all_gated();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
